// File: rtl/fir_mac_sequencer.sv
// Serial FIR sequencer: one shared MAC steps through all taps per accepted sample.
// Define FIR_SAT_EN to clip the rounded result to WIDTH bits instead of wrapping.
module fir_mac_sequencer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned FRAC  = 8,
    parameter int unsigned TAPS  = 8,
    localparam int unsigned AW   = $clog2(TAPS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sample,
    output logic [AW-1:0]    coef_addr,
    input  logic [WIDTH-1:0] coef_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_sample,
    output logic             out_sat
);

    localparam int unsigned ProdW = 2 * WIDTH;
    localparam int unsigned AccW  = ProdW + AW;

    localparam logic [AW-1:0]          LastTap   = AW'(TAPS - 1);
    localparam logic signed [AccW-1:0] RoundBias = AccW'(1) << (FRAC - 1);

    typedef enum logic [2:0] {StIdle, StLoad, StMac, StRound, StDone} state_e;

    state_e                  state_q;
    logic [WIDTH-1:0]        x_q [TAPS];
    logic [WIDTH-1:0]        sample_q;
    logic signed [AccW-1:0]  acc_q;

    logic [WIDTH-1:0]        x_tap;
    logic signed [ProdW-1:0] prod;
    logic signed [AccW-1:0]  prod_ext;
    logic signed [AccW-1:0]  acc_rnd;
    logic signed [AccW-1:0]  r_full;
    logic [WIDTH-1:0]        r_lim;
    logic                    r_sat;

    // Both operands sign-extended to full product width before the multiply.
    always_comb begin
        x_tap    = x_q[coef_addr];
        prod     = $signed({{WIDTH{x_tap[WIDTH-1]}}, x_tap})
                 * $signed({{WIDTH{coef_data[WIDTH-1]}}, coef_data});
        prod_ext = {{AW{prod[ProdW-1]}}, prod};
    end

    always_comb begin
        acc_rnd = acc_q + RoundBias;
        r_full  = acc_rnd >>> FRAC;
    end

`ifdef FIR_SAT_EN
    localparam logic signed [AccW-1:0] SatMax =
        {{(AccW - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [AccW-1:0] SatMin =
        {{(AccW - WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

    always_comb begin
        r_lim = r_full[WIDTH-1:0];
        r_sat = 1'b0;
        if (r_full > SatMax) begin
            r_lim = {1'b0, {(WIDTH - 1){1'b1}}};
            r_sat = 1'b1;
        end else if (r_full < SatMin) begin
            r_lim = {1'b1, {(WIDTH - 1){1'b0}}};
            r_sat = 1'b1;
        end
    end
`else
    logic unused_r_hi;
    assign unused_r_hi = ^r_full[AccW-1:WIDTH];

    always_comb begin
        r_lim = r_full[WIDTH-1:0];
        r_sat = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_sample <= '0;
            out_sat    <= 1'b0;
            coef_addr  <= '0;
            acc_q      <= '0;
            sample_q   <= '0;
            for (int k = 0; k < TAPS; k++) x_q[k] <= '0;
        end else if (clr) begin
            // out_sample/out_sat deliberately keep the last reported result.
            state_q   <= StIdle;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            coef_addr <= '0;
            acc_q     <= '0;
            for (int k = 0; k < TAPS; k++) x_q[k] <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        sample_q <= in_sample;
                        in_ready <= 1'b0;
                        state_q  <= StLoad;
                    end
                end
                StLoad: begin
                    x_q[0] <= sample_q;
                    for (int k = 1; k < TAPS; k++) x_q[k] <= x_q[k-1];
                    acc_q     <= '0;
                    coef_addr <= '0;
                    state_q   <= StMac;
                end
                StMac: begin
                    acc_q <= acc_q + prod_ext;
                    if (coef_addr == LastTap) begin
                        coef_addr <= '0;
                        state_q   <= StRound;
                    end else begin
                        coef_addr <= coef_addr + 1'b1;
                    end
                end
                StRound: begin
                    out_sample <= r_lim;
                    out_sat    <= r_sat;
                    out_valid  <= 1'b1;
                    state_q    <= StDone;
                end
                StDone: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state_q   <= StIdle;
                end
                default: begin
                    state_q  <= StIdle;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer: directed test-plan steps plus random traffic,
// checked cycle by cycle against an arithmetic reference model.
module tb_fir_mac_sequencer;

    localparam int W = 16;
    localparam int F = 8;
    localparam int T = 8;
    localparam int AW = $clog2(T);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_sample;
    logic [AW-1:0] coef_addr;
    logic [W-1:0]  coef_data;
    logic          out_valid;
    logic [W-1:0]  out_sample;
    logic          out_sat;

    logic [W-1:0]  coef [T];

    int n_assert = 0;
    int n_fail   = 0;

    fir_mac_sequencer #(.WIDTH(W), .FRAC(F), .TAPS(T)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sample (in_sample),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_valid (out_valid),
        .out_sample(out_sample),
        .out_sat   (out_sat)
    );

    assign coef_data = coef[coef_addr];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: history as a plain array, result by integer arithmetic.
    logic [W-1:0] hist [T];
    int           phase = 0;
    logic [W-1:0] pend_out = '0, shown_out = '0;
    logic         pend_sat = 1'b0, shown_sat = 1'b0;

    function automatic logic [W:0] model_eval();
        longint acc = 0;
        longint r;
        logic [63:0] rv;
        for (int k = 0; k < T; k++)
            acc += longint'($signed(hist[k])) * longint'($signed(coef[k]));
        r  = (acc + (longint'(1) <<< (F - 1))) >>> F;
        rv = r;
`ifdef FIR_SAT_EN
        if (r > 32767) return {1'b1, 16'h7FFF};
        if (r < -32768) return {1'b1, 16'h8000};
`endif
        return {1'b0, rv[W-1:0]};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase = 0;
            for (int k = 0; k < T; k++) hist[k] = '0;
            shown_out = '0;
            shown_sat = 1'b0;
        end else if (clr) begin
            phase = 0;
            for (int k = 0; k < T; k++) hist[k] = '0;
        end else if (phase == 0) begin
            if (in_valid) begin
                for (int k = T - 1; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = in_sample;
                {pend_sat, pend_out} = model_eval();
                phase = 1;
            end
        end else if (phase == T + 2) begin
            shown_out = pend_out;
            shown_sat = pend_sat;
            phase++;
        end else if (phase == T + 3) begin
            phase = 0;
        end else begin
            phase++;
        end
    end

    always @(negedge clk) begin
        chk("mon_in_ready", 32'(in_ready), 32'(phase == 0));
        chk("mon_out_valid", 32'(out_valid), 32'(phase == T + 3));
        chk("mon_coef_addr", 32'(coef_addr), (phase >= 2 && phase <= T + 1) ? phase - 2 : 0);
        chk("mon_out_sample", 32'(out_sample), 32'(shown_out));
        chk("mon_out_sat", 32'(out_sat), 32'(shown_sat));
    end

    task automatic send(input logic [W-1:0] s, output logic [W-1:0] got, output logic got_sat);
        int n = 0;
        int lat = 1;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", 32'(in_ready), 1);
        in_valid  = 1'b1;
        in_sample = s;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, T + 3);
        got     = out_sample;
        got_sat = out_sat;
    endtask

    task automatic clr_pulse();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] g;
        logic         gs;
        int           prev;
        int           nv;

        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_sample = '0;
        for (int k = 0; k < T; k++) coef[k] = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_sample", 32'(out_sample), 0);
        chk("rst_out_sat", 32'(out_sat), 0);
        chk("rst_coef_addr", 32'(coef_addr), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Impulse response walks out the coefficient table.
        for (int k = 0; k < T; k++) coef[k] = W'(16 * (k + 1));
        for (int i = 0; i < T; i++) begin
            send((i == 0) ? 16'h0100 : 16'h0000, g, gs);
            chk("impulse", 32'(g), 16 * (i + 1));
        end

        // Rounding half toward +inf.
        @(negedge clk);
        clr_pulse();
        for (int k = 0; k < T; k++) coef[k] = 16'h0080;
        send(16'h0001, g, gs);
        chk("round_pos", 32'(g), 32'h0001);
        @(negedge clk);
        clr_pulse();
        send(16'hFFFF, g, gs);
        chk("round_neg", 32'(g), 32'h0000);

        // Full-scale accumulation.
        @(negedge clk);
        clr_pulse();
        for (int k = 0; k < T; k++) coef[k] = 16'h7FFF;
        for (int i = 0; i < T; i++) send(16'h7FFF, g, gs);
`ifdef FIR_SAT_EN
        chk("sat_value", 32'(g), 32'h7FFF);
        chk("sat_flag", 32'(gs), 1);
`else
        chk("wrap_value", 32'(g), 32'hF800);
        chk("wrap_flag", 32'(gs), 0);
`endif

        // in_valid held high: one accept every T+4 cycles.
        @(negedge clk);
        clr_pulse();
        in_sample = 16'h0040;
        in_valid  = 1'b1;
        prev = -1;
        for (int c = 0; c < 40; c++) begin
            if (in_ready) begin
                if (prev >= 0) chk("accept_gap", c - prev, T + 4);
                prev = c;
            end
            @(negedge clk);
        end
        chk("accept_last", prev, 36);
        in_valid = 1'b0;
        repeat (14) @(negedge clk);

        // clr in the middle of MAC.
        coef[0] = 16'h0100;
        for (int k = 1; k < T; k++) coef[k] = W'($urandom);
        send(W'($urandom), g, gs);
        @(negedge clk);
        in_sample = 16'h1234;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        clr_pulse();
        nv = 0;
        for (int c = 0; c < 20; c++) begin
            if (out_valid) nv++;
            @(negedge clk);
        end
        chk("clr_no_valid", nv, 0);
        send(16'h0100, g, gs);
        chk("clr_history", 32'(g), 32'h0100);

        // Asynchronous reset mid-MAC.
        @(negedge clk);
        in_sample = W'($urandom);
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 32'(in_ready), 1);
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_out_sample", 32'(out_sample), 0);
        chk("arst_out_sat", 32'(out_sat), 0);
        chk("arst_coef_addr", 32'(coef_addr), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("arst_ready_after", 32'(in_ready), 1);
        send(16'h0100, g, gs);
        chk("arst_history", 32'(g), 32'h0100);

        // Random traffic with occasional clears, checked by the monitor.
        @(negedge clk);
        for (int k = 0; k < T; k++)
            coef[k] = (k == 3) ? W'($urandom) : W'($urandom_range(0, 511) - 256);
        for (int c = 0; c < 600; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_sample = W'($urandom);
            clr       = ($urandom_range(0, 59) == 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        clr      = 1'b0;
        repeat (15) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_mac_sequencer.md
# fir_mac_sequencer

Sequencer for the team's fixed-point filter datapath. It accepts one Q-format sample per handshake and shifts it into an internal delay line. It then steps one shared multiplier/accumulator through every tap, fetching coefficients from an external coefficient store, and returns a rounded, range-limited result in the same Q format as the input. The products are built at double width, with the sign extended and the binary point aligned, before accumulation.

## Interface
- WIDTH, 16, sample/coefficient width in bits (two's complement, 1 sign bit)
- FRAC, 8, fractional bits of samples, coefficients and output (FRAC >= 1, FRAC < WIDTH-1)
- TAPS, 8, number of filter taps (2..64)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- clr  input  1  synchronous clear of delay line and sequence
- in_valid  input  1  sample offered
- in_ready  output  1  block can accept a sample (IDLE only)
- in_sample  input  WIDTH  input sample, Q(WIDTH-1-FRAC).FRAC
- coef_addr  output  clog2(TAPS)  coefficient index k
- coef_data  input  WIDTH  coefficient c[k], combinational from coef_addr, same Q format
- out_valid  output  1  one-cycle pulse, out_sample valid
- out_sample  output  WIDTH  filtered result, held until next out_valid
- out_sat  output  1  result was clipped, qualified by out_valid

## Operation
- FSM states: IDLE, LOAD, MAC, ROUND, DONE.
- IDLE: in_ready=1. When in_valid is high, the sample is accepted and the FSM goes to LOAD.
- LOAD: shift the delay line (x[0]=new sample, x[k]=old x[k-1], oldest dropped); clear the accumulator; set k=0. Next state is MAC.
- MAC: coef_addr=k. Each cycle, acc += x[k]*coef_data, with the product taken as a signed 2·WIDTH-bit value carrying 2·FRAC fraction bits. k increments each cycle. After k=TAPS-1, go to ROUND.
- Accumulator width: 2·WIDTH+clog2(TAPS) bits, so no internal overflow can occur.
- ROUND: r = (acc + 2^(FRAC-1)) >>> FRAC (arithmetic shift, round half toward +inf). Range-limit r to WIDTH bits per Configuration, register it into out_sample, and go to DONE.
- DONE: out_valid=1 for exactly one cycle, then return to IDLE.
- clr high in any state: on the next edge, zero the delay line, zero the accumulator and go to IDLE. No out_valid is produced, the in-flight sample is discarded, and out_sample keeps its last value. clr takes priority over in_valid in the same cycle, and that sample is not accepted.
- in_valid outside IDLE is ignored; in_ready=0 there. Upstream must hold the sample until the handshake.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, in_ready=1, out_valid=0, out_sample=0, out_sat=0, coef_addr=0, delay line and accumulator zero.
- Handshake at edge 0 gives LOAD in cycle 1, MAC in cycles 2..TAPS+1, ROUND in cycle TAPS+2, and DONE (out_valid=1) in cycle TAPS+3.
- Latency from accept to out_valid: TAPS+3 cycles. Throughput: one sample per TAPS+4 cycles. in_ready rises in the cycle after DONE.
- coef_addr changes only on clock edges. Outside MAC it is 0.
- Reset released mid-sequence restarts in IDLE with cleared history.

## Configuration
- FIR_SAT_EN defined: if r > 2^(WIDTH-1)-1, out_sample=0x7FF..F and out_sat=1. If r < -2^(WIDTH-1), out_sample=0x800..0 and out_sat=1. Otherwise out_sample=r[WIDTH-1:0] and out_sat=0.
- FIR_SAT_EN undefined: out_sample=r[WIDTH-1:0] (two's-complement wrap). out_sat is tied to 0.

## Test plan
Defaults throughout: WIDTH=16, FRAC=8, TAPS=8.
- Impulse: coefficients c[k]=16·(k+1), then sample 0x0100 (1.0) followed by seven 0x0000 samples. out_sample must read 0x0010, 0x0020 … 0x0080 in order, with out_valid exactly TAPS+3 cycles after each accept.
- Rounding: all c=0x0080 (0.5), a single sample 0x0001 in a cleared line. Result must be 0x0001. With sample 0xFFFF (-1 LSB), the result must be 0x0000.
- Saturation: all c=0x7FFF, eight samples 0x7FFF. The final output must be 0x7FFF with out_sat=1 under FIR_SAT_EN. Without the macro, it must equal the low 16 bits of r, with out_sat=0.
- Handshake: hold in_valid high continuously. Samples must be accepted every 12 cycles, with in_ready=0 from LOAD through DONE.
- clr during MAC (cycle 5 after accept): no out_valid pulse. The next sample 0x0100 with c[0]=0x0100 must yield 0x0100, proving the history was cleared.
- Assert rst_n=0 mid-MAC, asynchronous to clk. All outputs must be at their reset values immediately, and in_ready=1 after release.
